// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory port arbiter.
// Latency: none, wiring only.
// Backpressure: requests are levels held until ack; the memory side uses enable/done pulses.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ   = 3,
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 16
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Requester side
    logic [NUM_REQ-1:0]           req_rden;
    logic [NUM_REQ-1:0]           req_wren;
    logic [NUM_REQ*ADDR_W-1:0]    req_addr;
    logic [NUM_REQ*WORD_SIZE-1:0] req_wdata;
    logic [NUM_REQ-1:0]           req_ack;
    logic                         req_err;
    logic [WORD_SIZE-1:0]         rsp_rdata;
    logic [IDX_W-1:0]             grant_id;
    logic                         busy;

    // Read/write FSM side
    logic                         mem_rden;
    logic                         mem_wren;
    logic [ADDR_W-1:0]            mem_addr;
    logic [WORD_SIZE-1:0]         mem_wdata;
    logic                         mem_done;
    logic [WORD_SIZE-1:0]         mem_rdata;

    // The arbiter serves the bundle: it consumes requests and the RW FSM completion.
    modport slave (
        input  req_rden, req_wren, req_addr, req_wdata, mem_done, mem_rdata,
        output req_ack, req_err, rsp_rdata, grant_id, busy,
               mem_rden, mem_wren, mem_addr, mem_wdata
    );

    // The environment (requesters plus RW FSM) drives the bundle.
    modport master (
        output req_rden, req_wren, req_addr, req_wdata, mem_done, mem_rdata,
        input  req_ack, req_err, rsp_rdata, grant_id, busy,
               mem_rden, mem_wren, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read/write port among NUM_REQ requesters, with watchdog.
// Latency: request to mem enable 1 cycle, mem_done to ack 1 cycle, 4 cycles minimum request to ack.
// Backpressure: one transaction in flight; losing requesters hold their level requests until acked.
module mem_port_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Wide enough to hold TIMEOUT itself, so the count never wraps before the abort.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q,  state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic                 rd_op_q,  rd_op_d;
    logic [ADDR_W-1:0]    addr_q,   addr_d;
    logic [WORD_SIZE-1:0] wdata_q,  wdata_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [WORD_SIZE-1:0] rdata_q,  rdata_d;
    logic [NUM_REQ-1:0]   ack_q,    ack_d;
    logic                 err_q,    err_d;
    logic                 rden_q,   rden_d;
    logic                 wren_q,   wren_d;
    logic                 busy_q,   busy_d;

    logic [NUM_REQ-1:0]   pending;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;

    // Find the first pending requester scanning upward from rr_ptr with wrap.
    always_comb begin
        pending  = bus.req_rden | bus.req_wren;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_vld && pending[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and next-output logic; every output is the image of a register.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        rd_op_d  = rd_op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        ack_d    = '0;
        err_d    = 1'b0;
        rden_d   = 1'b0;
        wren_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    // Latch everything now so later requester changes are ignored.
                    idx_d   = pick_idx;
                    addr_d  = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = bus.req_wdata[pick_idx*WORD_SIZE +: WORD_SIZE];
                    rd_op_d = bus.req_rden[pick_idx];
                    // Read wins when a requester raises both enables.
                    rden_d  = bus.req_rden[pick_idx];
                    wren_d  = !bus.req_rden[pick_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_done) begin
                    if (rd_op_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    ack_d[idx_q] = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        ack_d[idx_q] = 1'b1;
                        err_d        = 1'b1;
                        state_d      = S_RESP;
                    end
                end
            end
            S_RESP: begin
                rr_ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            rd_op_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            rd_op_q  <= rd_op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rden_q   <= rden_d;
            wren_q   <= wren_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.req_ack   = ack_q;
    assign bus.req_err   = err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.grant_id  = idx_q;
    assign bus.busy      = busy_q;
    assign bus.mem_rden  = rden_q;
    assign bus.mem_wren  = wren_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, rd+wr priority, round-robin, timeout, reset abort, stray done.
// Latency: every step advances one clock edge and samples 1 time unit after it.
// Backpressure: requesters hold levels until ack and drop them during the ack cycle.
module tb_mem_port_arbiter;
    localparam int NUM_REQ   = 3;
    localparam int WORD_SIZE = 32;
    localparam int ADDR_W    = 16;
    localparam int TIMEOUT   = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_rdata;

    mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WORD_SIZE(WORD_SIZE),
        .ADDR_W   (ADDR_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst           = 1'b1;
        bus.req_rden  = '0;
        bus.req_wren  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = '0;
        #2;

        // Reset values
        check("rst_busy",  64'(bus.busy),      64'h0);
        check("rst_grant", 64'(bus.grant_id),  64'h0);
        check("rst_ack",   64'(bus.req_ack),   64'h0);
        check("rst_err",   64'(bus.req_err),   64'h0);
        check("rst_rdata", 64'(bus.rsp_rdata), 64'h0);
        check("rst_rden",  64'(bus.mem_rden),  64'h0);
        check("rst_wren",  64'(bus.mem_wren),  64'h0);
        check("rst_addr",  64'(bus.mem_addr),  64'h0);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_busy", 64'(bus.busy), 64'h0);

        // Single read by requester 1, done on the third WAIT cycle
        bus.req_rden[1]         = 1'b1;
        bus.req_addr[16 +: 16]  = 16'h0040;
        step();                                     // ISSUE
        check("rd_issue_rden",  64'(bus.mem_rden), 64'h1);
        check("rd_issue_wren",  64'(bus.mem_wren), 64'h0);
        check("rd_issue_addr",  64'(bus.mem_addr), 64'h0040);
        check("rd_issue_grant", 64'(bus.grant_id), 64'h1);
        check("rd_issue_busy",  64'(bus.busy),     64'h1);
        step();                                     // WAIT1
        check("rd_wait_rden",   64'(bus.mem_rden), 64'h0);
        check("rd_wait_addr",   64'(bus.mem_addr), 64'h0040);
        step();                                     // WAIT2
        step();                                     // WAIT3
        check("rd_noack_early", 64'(bus.req_ack),  64'h0);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        step();                                     // RESP
        bus.mem_done    = 1'b0;
        bus.req_rden[1] = 1'b0;
        check("rd_ack",   64'(bus.req_ack),   64'h2);
        check("rd_err",   64'(bus.req_err),   64'h0);
        check("rd_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
        step();                                     // IDLE
        check("rd_ack_pulse", 64'(bus.req_ack), 64'h0);
        check("rd_idle_busy", 64'(bus.busy),    64'h0);

        // Requester 2 raises read and write together; read must win
        bus.req_rden[2]        = 1'b1;
        bus.req_wren[2]        = 1'b1;
        bus.req_addr[32 +: 16] = 16'h0123;
        step();                                     // ISSUE
        check("rw_rden",  64'(bus.mem_rden), 64'h1);
        check("rw_wren",  64'(bus.mem_wren), 64'h0);
        check("rw_grant", 64'(bus.grant_id), 64'h2);
        check("rw_addr",  64'(bus.mem_addr), 64'h0123);
        step();                                     // WAIT1
        check("rw_wait_wren", 64'(bus.mem_wren), 64'h0);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'h12345678;
        step();                                     // RESP
        bus.mem_done    = 1'b0;
        bus.req_rden[2] = 1'b0;
        bus.req_wren[2] = 1'b0;
        check("rw_ack",   64'(bus.req_ack),   64'h4);
        check("rw_rdata", 64'(bus.rsp_rdata), 64'h12345678);
        step();                                     // IDLE

        // Round-robin with all three continuously pending, done on first WAIT cycle
        bus.req_wren[0]        = 1'b1;
        bus.req_rden[1]        = 1'b1;
        bus.req_rden[2]        = 1'b1;
        bus.req_wren[2]        = 1'b1;
        bus.req_addr[0 +: 16]  = 16'h0010;
        bus.req_wdata[0 +: 32] = 32'hA5A50000;
        exp_rdata              = 32'h12345678;
        for (int t = 0; t < 6; t++) begin
            int e;
            e = t % 3;
            step();                                 // ISSUE
            check("rr_grant", 64'(bus.grant_id), 64'(e));
            check("rr_rden",  64'(bus.mem_rden), 64'(e != 0));
            check("rr_wren",  64'(bus.mem_wren), 64'(e == 0));
            if (e == 0) begin
                check("rr_wdata", 64'(bus.mem_wdata), 64'hA5A50000);
            end
            step();                                 // WAIT1
            bus.mem_done  = 1'b1;
            bus.mem_rdata = 32'h10000000 + 32'(t);
            if (e != 0) begin
                exp_rdata = 32'h10000000 + 32'(t);
            end
            step();                                 // RESP
            bus.mem_done = 1'b0;
            check("rr_ack",   64'(bus.req_ack),   64'(3'b001 << e));
            check("rr_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
            if (t == 5) begin
                bus.req_rden = '0;
                bus.req_wren = '0;
            end
            step();                                 // IDLE
        end

        // Watchdog timeout: no done, four WAIT cycles then error ack
        bus.req_rden[0]       = 1'b1;
        bus.req_addr[0 +: 16] = 16'h0200;
        step();                                     // ISSUE
        check("to_grant", 64'(bus.grant_id), 64'h0);
        step();                                     // WAIT1
        for (int c = 1; c < 4; c++) begin
            check("to_wait_noack", 64'(bus.req_ack), 64'h0);
            step();                                 // WAIT2..WAIT4
        end
        check("to_wait4_noack", 64'(bus.req_ack), 64'h0);
        step();                                     // RESP
        check("to_ack",   64'(bus.req_ack),   64'h1);
        check("to_err",   64'(bus.req_err),   64'h1);
        check("to_rdata", 64'(bus.rsp_rdata), 64'h10000005);
        bus.req_rden[0] = 1'b0;
        step();                                     // IDLE
        check("to_err_pulse", 64'(bus.req_err), 64'h0);
        check("to_ack_pulse", 64'(bus.req_ack), 64'h0);

        // Next request after the timeout is served normally (write by requester 1)
        bus.req_wren[1]         = 1'b1;
        bus.req_addr[16 +: 16]  = 16'h0044;
        bus.req_wdata[32 +: 32] = 32'hCAFEF00D;
        step();                                     // ISSUE
        check("wr_wren",  64'(bus.mem_wren),  64'h1);
        check("wr_rden",  64'(bus.mem_rden),  64'h0);
        check("wr_grant", 64'(bus.grant_id),  64'h1);
        check("wr_addr",  64'(bus.mem_addr),  64'h0044);
        check("wr_wdata", 64'(bus.mem_wdata), 64'hCAFEF00D);
        step();                                     // WAIT1
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'hFFFFFFFF;
        step();                                     // RESP
        bus.mem_done    = 1'b0;
        bus.req_wren[1] = 1'b0;
        check("wr_ack",   64'(bus.req_ack),   64'h2);
        check("wr_err",   64'(bus.req_err),   64'h0);
        check("wr_rdata", 64'(bus.rsp_rdata), 64'h10000005);
        step();                                     // IDLE, rr_ptr now 2

        // Reset in the middle of WAIT
        bus.req_rden[2]        = 1'b1;
        bus.req_addr[32 +: 16] = 16'h0300;
        step();                                     // ISSUE
        check("mr_grant", 64'(bus.grant_id), 64'h2);
        step();                                     // WAIT1
        rst = 1'b1;
        #1;
        check("mr_busy",  64'(bus.busy),      64'h0);
        check("mr_grant0",64'(bus.grant_id),  64'h0);
        check("mr_addr",  64'(bus.mem_addr),  64'h0);
        check("mr_rdata", 64'(bus.rsp_rdata), 64'h0);
        check("mr_ack",   64'(bus.req_ack),   64'h0);
        step();
        rst                   = 1'b0;
        bus.req_rden[0]       = 1'b1;
        bus.req_addr[0 +: 16] = 16'h0500;
        check("mr_noack_idle", 64'(bus.req_ack), 64'h0);
        step();                                     // ISSUE
        check("mr_next_grant", 64'(bus.grant_id), 64'h0);
        check("mr_next_addr",  64'(bus.mem_addr), 64'h0500);
        check("mr_noack",      64'(bus.req_ack),  64'h0);
        step();                                     // WAIT1
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'h0BADCAFE;
        step();                                     // RESP
        bus.mem_done    = 1'b0;
        bus.req_rden[0] = 1'b0;
        check("mr_ack0",   64'(bus.req_ack),   64'h1);
        check("mr_rdata0", 64'(bus.rsp_rdata), 64'h0BADCAFE);
        step();                                     // IDLE
        step();                                     // ISSUE for the re-requesting 2
        check("mr_grant2", 64'(bus.grant_id), 64'h2);
        check("mr_addr2",  64'(bus.mem_addr), 64'h0300);
        step();                                     // WAIT1
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'h22220000;
        step();                                     // RESP
        bus.mem_done    = 1'b0;
        bus.req_rden[2] = 1'b0;
        check("mr_ack2",   64'(bus.req_ack),   64'h4);
        check("mr_rdata2", 64'(bus.rsp_rdata), 64'h22220000);
        step();                                     // IDLE

        // Stray done pulses in IDLE and ISSUE are ignored
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'hBADBAD00;
        step();                                     // still IDLE
        check("sp_idle_busy",  64'(bus.busy),      64'h0);
        check("sp_idle_ack",   64'(bus.req_ack),   64'h0);
        check("sp_idle_rdata", 64'(bus.rsp_rdata), 64'h22220000);
        bus.mem_done           = 1'b0;
        bus.req_rden[1]        = 1'b1;
        bus.req_addr[16 +: 16] = 16'h0600;
        step();                                     // ISSUE
        check("sp_grant", 64'(bus.grant_id), 64'h1);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'hBADBAD01;
        step();                                     // WAIT1
        bus.mem_done = 1'b0;
        check("sp_wait1_ack", 64'(bus.req_ack), 64'h0);
        check("sp_wait1_busy",64'(bus.busy),    64'h1);
        step();                                     // WAIT2
        check("sp_wait2_ack", 64'(bus.req_ack), 64'h0);
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 32'h600DF00D;
        step();                                     // RESP
        bus.mem_done    = 1'b0;
        bus.req_rden[1] = 1'b0;
        check("sp_ack",   64'(bus.req_ack),   64'h2);
        check("sp_err",   64'(bus.req_err),   64'h0);
        check("sp_rdata", 64'(bus.rsp_rdata), 64'h600DF00D);
        step();                                     // IDLE
        check("sp_end_busy", 64'(bus.busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory read/write port between NUM_REQ requesters, e.g. fetch, eval and cons/GC allocator.
- Grants are round-robin; one transaction is outstanding at a time.
- Issues a one-cycle enable pulse to the downstream read/write FSM, waits for its completion pulse, then returns read data and an ack to the granted requester.
- A watchdog aborts transactions whose completion never arrives.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WORD_SIZE, 32, data word width.
- ADDR_W, 16, address width.
- TIMEOUT, 255, maximum WAIT cycles before abort (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_rden  in  NUM_REQ  per-requester read request; level, held until ack.
- req_wren  in  NUM_REQ  per-requester write request; level, held until ack.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
- req_wdata  in  NUM_REQ*WORD_SIZE  packed write data.
- req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- req_err  out  1  high with req_ack when the transaction timed out.
- rsp_rdata  out  WORD_SIZE  read data; valid in the ack cycle, held until the next ack.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- busy  out  1  high in every state except IDLE.
- mem_rden  out  1  read enable pulse to the RW FSM.
- mem_wren  out  1  write enable pulse to the RW FSM.
- mem_addr  out  ADDR_W  address to the RW FSM.
- mem_wdata  out  WORD_SIZE  write data to the RW FSM.
- mem_done  in  1  one-cycle completion pulse from the RW FSM.
- mem_rdata  in  WORD_SIZE  read data from the RW FSM; valid when mem_done=1.

Behaviour:
- Reset: all outputs are 0 and FSM=IDLE; rr_ptr=0 and wait counter=0. Asserting rst mid-transaction aborts it with no ack; requesters re-request after reset.
- All outputs are registered.
- States IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - A requester is pending when req_rden[i] or req_wren[i] is set.
  - Pick the first pending index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Latch idx, addr, wdata and op. Read wins if both rden and wren are set by the same requester.
  - Go to ISSUE; grant_id=idx. With nothing pending, stay in IDLE.
- ISSUE:
  - Drive mem_addr/mem_wdata from the latched values.
  - Assert mem_rden or mem_wren for exactly this one cycle.
  - Clear the counter and go to WAIT.
- WAIT:
  - mem_addr/mem_wdata stay stable; enables are 0.
  - On mem_done=1: capture mem_rdata (read only; writes leave rsp_rdata unchanged) and go to RESP with err=0.
  - Otherwise increment the counter. When counter reaches TIMEOUT, go to RESP with err=1 and leave rsp_rdata unchanged.
- RESP:
  - req_ack[idx]=1 and req_err=err for one cycle.
  - rr_ptr = (idx+1) mod NUM_REQ; go to IDLE.
- Latency:
  - Request seen at edge N → mem enable high in cycle N+1.
  - mem_done sampled high at edge M → ack in cycle M+1.
  - Minimum request-to-ack is 4 cycles (done on the first WAIT cycle).
- mem_done outside WAIT is ignored; it is not counted and not stored.
- Requester contract:
  - Hold req and its addr/wdata until ack is seen.
  - Drop req on the edge ending the ack cycle, so the following IDLE does not re-grant it.
  - Changing addr/wdata after grant has no effect; the values are latched in IDLE.
- A requester withdrawing req after grant does not cancel the transaction; the ack is still issued.
- Fairness: with all requesters continuously pending, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- rr_ptr wraps from NUM_REQ-1 to 0.
- The wait counter is ADDR-independent and $clog2(TIMEOUT+1) bits wide; it never wraps before the timeout fires.

Test Plan:
- Single read: req_rden[1]=1, addr=0x0040; RW returns mem_done after 3 WAIT cycles with rdata=0xDEADBEEF → mem_rden pulse with mem_addr=0x0040, then req_ack=3'b010, rsp_rdata=0xDEADBEEF, req_err=0, 6 cycles after request.
- Round-robin: all three requesters pending continuously, done returned immediately → grant order 0,1,2,0,1,2; each ack 4 cycles apart; no starvation.
- Rd+wr same requester: req_rden[2]=req_wren[2]=1 → only mem_rden pulses, mem_wren stays 0.
- Timeout: TIMEOUT=4, mem_done never asserted → ack with req_err=1 exactly 4 WAIT cycles after ISSUE; rsp_rdata keeps its prior value; next request is served normally.
- Reset mid-WAIT: assert rst during WAIT → all outputs 0 immediately (async); after release, no ack for the aborted transaction; grant_id=0 on the next arbitration.
- Spurious done: mem_done pulsed while IDLE, then a read issued → the stray pulse is ignored; ack only follows the in-WAIT done.
